// File: rtl/calc_line_ctrl.sv
// Line editor front-end for a calculator: buffers typed characters, launches a
// calculation on carriage return and latches the result. Optional watchdog: CALC_TIMEOUT_EN.
module calc_line_ctrl #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned AW          = 6,
  parameter int unsigned RES_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic [7:0]       ascii_in,
  input  logic             data_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic [7:0]       rd_data,
  output logic             calc_start,
  input  logic             calc_done,
  input  logic [RES_W-1:0] calc_result,
  output logic [RES_W-1:0] result,
  output logic             done_flag,
  output logic             busy,
  output logic             overflow,
  output logic [AW:0]      len
`ifdef CALC_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  localparam logic [AW:0] LEN_LAST = (AW+1)'(DEPTH - 1);
  localparam int unsigned WD_W     = $clog2(TIMEOUT_CYC + 1);

  // Reject configurations the buffer addressing and watchdog cannot support.
  if (DEPTH < 4 || DEPTH != (1 << AW) || TIMEOUT_CYC < 2 || WD_W < 1) begin : g_bad_cfg
    $error("calc_line_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_EDIT  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_buf [DEPTH];
  logic [AW:0]      w_len_nxt;
  logic [RES_W-1:0] w_result_nxt;
  logic             w_done_nxt;
  logic             w_ovf_nxt;
  logic             w_start_nxt;
  logic             w_busy_nxt;
  logic             w_wr_en;
  logic             w_printable;

`ifdef CALC_TIMEOUT_EN
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] r_wd;
  logic [WD_W-1:0] w_wd_nxt;
  logic            w_to_nxt;
`endif

  assign w_printable = (ascii_in >= 8'h20) && (ascii_in <= 8'h7E);
  assign rd_data     = r_buf[rd_addr];

  // Next-state and next-output logic; registered outputs follow the next state.
  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = len;
    w_result_nxt = result;
    w_done_nxt   = done_flag;
    w_ovf_nxt    = overflow;
    w_wr_en      = 1'b0;
`ifdef CALC_TIMEOUT_EN
    w_wd_nxt     = r_wd;
    w_to_nxt     = timeout;
`endif
    unique case (r_state)
      S_EDIT: begin
        if (data_ready) begin
          if (w_printable) begin
            if (len < LEN_LAST) begin
              w_wr_en   = 1'b1;
              w_len_nxt = len + (AW+1)'(1);
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end else if (ascii_in == 8'h08) begin
            if (len != '0) w_len_nxt = len - (AW+1)'(1);
          end else if ((ascii_in == 8'h0D) && (len != '0)) begin
            w_wr_en     = 1'b1;
            w_done_nxt  = 1'b0;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = S_START;
`ifdef CALC_TIMEOUT_EN
            w_wd_nxt    = '0;
            w_to_nxt    = 1'b0;
`endif
          end
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
`ifdef CALC_TIMEOUT_EN
        w_wd_nxt    = WD_W'(1);
`endif
      end
      S_WAIT: begin
        if (calc_done) begin
          w_result_nxt = calc_result;
          w_done_nxt   = 1'b1;
          w_len_nxt    = '0;
          w_state_nxt  = S_EDIT;
        end
`ifdef CALC_TIMEOUT_EN
        // Watchdog counts from the START cycle so EDIT returns TIMEOUT_CYC clocks after START.
        else if (r_wd >= WD_LAST) begin
          w_len_nxt   = '0;
          w_to_nxt    = 1'b1;
          w_state_nxt = S_EDIT;
        end else begin
          w_wd_nxt = r_wd + WD_W'(1);
        end
`endif
      end
      default: w_state_nxt = S_EDIT;
    endcase
    w_start_nxt = (w_state_nxt == S_START);
    w_busy_nxt  = (w_state_nxt != S_EDIT);
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_state    <= S_EDIT;
      len        <= '0;
      result     <= '0;
      done_flag  <= 1'b0;
      overflow   <= 1'b0;
      calc_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      len        <= w_len_nxt;
      result     <= w_result_nxt;
      done_flag  <= w_done_nxt;
      overflow   <= w_ovf_nxt;
      calc_start <= w_start_nxt;
      busy       <= w_busy_nxt;
    end
  end

`ifdef CALC_TIMEOUT_EN
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_wd    <= '0;
      timeout <= 1'b0;
    end else begin
      r_wd    <= w_wd_nxt;
      timeout <= w_to_nxt;
    end
  end
`endif

  // Line buffer keeps its contents through reset.
  always_ff @(posedge clk_50m) begin
    if (w_wr_en) r_buf[len[AW-1:0]] <= ascii_in;
  end

endmodule

// File: tb/tb_calc_line_ctrl.sv
// Scoreboard bench for calc_line_ctrl (DEPTH=4): every expected change of the
// status outputs is queued by the stimulus and checked by an independent monitor.
module tb_calc_line_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned RES_W = 16;
  localparam int unsigned TOC   = 20;

  logic             clk_50m = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       ascii_in = 8'h00;
  logic             data_ready = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic [7:0]       rd_data;
  logic             calc_start;
  logic             calc_done = 1'b0;
  logic [RES_W-1:0] calc_result = '0;
  logic [RES_W-1:0] result;
  logic             done_flag;
  logic             busy;
  logic             overflow;
  logic [AW:0]      len;
`ifdef CALC_TIMEOUT_EN
  logic             timeout;
`endif

  calc_line_ctrl #(.DEPTH(DEPTH), .AW(AW), .RES_W(RES_W), .TIMEOUT_CYC(TOC)) dut (
    .clk_50m(clk_50m), .rst(rst), .ascii_in(ascii_in), .data_ready(data_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .calc_start(calc_start),
    .calc_done(calc_done), .calc_result(calc_result), .result(result),
    .done_flag(done_flag), .busy(busy), .overflow(overflow), .len(len)
`ifdef CALC_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct packed {
    logic [AW:0]      ln;
    logic             st;
    logic             bz;
    logic             dn;
    logic             ov;
    logic [RES_W-1:0] res;
  } snap_t;

  snap_t exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;

  function automatic snap_t snap();
    snap_t s;
    s.ln = len; s.st = calc_start; s.bz = busy; s.dn = done_flag; s.ov = overflow; s.res = result;
    return s;
  endfunction

  task automatic push(input string tag, input int ln, input bit st, input bit bz,
                      input bit dn, input bit ov, input int res);
    snap_t s;
    s.ln = (AW+1)'(ln); s.st = st; s.bz = bz; s.dn = dn; s.ov = ov; s.res = RES_W'(res);
    exp_q.push_back(s);
    tag_q.push_back(tag);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: any change of the status outputs must match the next queued expectation.
  initial begin
    snap_t prev, cur, e;
    string tag;
    prev = snap();
    forever begin
      @(negedge clk_50m);
      cur = snap();
      if (mon_en && cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got len=%0d start=%0b busy=%0b done=%0b ovf=%0b res=0x%0h, expected no change",
                   cur.ln, cur.st, cur.bz, cur.dn, cur.ov, cur.res);
        end else begin
          e = exp_q.pop_front();
          tag = tag_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL %s: got len=%0d start=%0b busy=%0b done=%0b ovf=%0b res=0x%0h, expected len=%0d start=%0b busy=%0b done=%0b ovf=%0b res=0x%0h",
                     tag, cur.ln, cur.st, cur.bz, cur.dn, cur.ov, cur.res,
                     e.ln, e.st, e.bz, e.dn, e.ov, e.res);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic key(input logic [7:0] c);
    @(posedge clk_50m); #1;
    ascii_in = c; data_ready = 1'b1;
    @(posedge clk_50m); #1;
    data_ready = 1'b0;
  endtask

  task automatic done_pulse(input int res, input bit with_key);
    @(posedge clk_50m); #1;
    calc_done = 1'b1; calc_result = RES_W'(res);
    if (with_key) begin ascii_in = 8'h35; data_ready = 1'b1; end
    @(posedge clk_50m); #1;
    calc_done = 1'b0; data_ready = 1'b0;
  endtask

  task automatic rd_check(input string name, input int addr, input int exp);
    rd_addr = AW'(addr);
    #1;
    check(name, int'(rd_data), exp);
  endtask

  initial begin
    repeat (3) @(posedge clk_50m);
    #1;
    check("rst_len", int'(len), 0);
    check("rst_busy_start", int'({busy, calc_start}), 0);
    check("rst_flags", int'({done_flag, overflow}), 0);
    check("rst_result", int'(result), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // "1+2" then CR launches a calculation.
    push("key_1", 1, 0, 0, 0, 0, 0);      key(8'h31);
    push("key_plus", 2, 0, 0, 0, 0, 0);   key(8'h2B);
    push("key_2", 3, 0, 0, 0, 0, 0);      key(8'h32);
    push("cr_start", 3, 1, 1, 0, 0, 0);
    push("cr_wait", 3, 0, 1, 0, 0, 0);    key(8'h0D);
    @(posedge clk_50m); #1;
    rd_check("buf0", 0, 8'h31);
    rd_check("buf1", 1, 8'h2B);
    rd_check("buf2", 2, 8'h32);
    rd_check("buf3_cr", 3, 8'h0D);
    key(8'h35);                                        // dropped in WAIT
    push("done_3", 0, 0, 0, 1, 0, 3);     done_pulse(3, 1'b1);  // key with calc_done dropped

    // Overflow at DEPTH-1 characters, then backspace down to empty.
    push("ov_1", 1, 0, 0, 1, 0, 3);       key(8'h31);
    push("ov_2", 2, 0, 0, 1, 0, 3);       key(8'h32);
    push("ov_3", 3, 0, 0, 1, 0, 3);       key(8'h33);
    push("ov_drop", 3, 0, 0, 1, 1, 3);    key(8'h34);
    push("bs_2", 2, 0, 0, 1, 1, 3);       key(8'h08);
    push("bs_1", 1, 0, 0, 1, 1, 3);       key(8'h08);
    push("bs_0", 0, 0, 0, 1, 1, 3);       key(8'h08);
    key(8'h08);                                        // backspace on empty line
    key(8'h0D);                                        // CR on empty line
    key(8'h07); key(8'h7F); key(8'h1F);                // non-printable
    push("pr_7e", 1, 0, 0, 1, 1, 3);      key(8'h7E);
    push("pr_20", 2, 0, 0, 1, 1, 3);      key(8'h20);
    rd_check("buf0_7e", 0, 8'h7E);
    rd_check("buf1_20", 1, 8'h20);
    rd_check("buf2_kept", 2, 8'h33);
    done_pulse(16'h55, 1'b0);                          // calc_done in EDIT ignored

    // Reset mid-WAIT aborts; a late calc_done is ignored.
    push("cr2_start", 2, 1, 1, 0, 0, 3);
    push("cr2_wait", 2, 0, 1, 0, 0, 3);   key(8'h0D);
    repeat (2) @(posedge clk_50m);
    #1;
    push("abort_rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk_50m); #1;
    rst = 1'b0;
    done_pulse(16'h55, 1'b0);
    check("abort_result", int'(result), 0);
    check("abort_done_busy", int'({done_flag, busy}), 0);

    push("k9", 1, 0, 0, 0, 0, 0);         key(8'h39);
    push("cr3_start", 1, 1, 1, 0, 0, 0);
    push("cr3_wait", 1, 0, 1, 0, 0, 0);   key(8'h0D);
    rd_check("buf1_cr", 1, 8'h0D);
    push("done_beef", 0, 0, 0, 1, 0, 16'hBEEF);  done_pulse(16'hBEEF, 1'b0);

`ifdef CALC_TIMEOUT_EN
    begin
      int n;
      push("to_k7", 1, 0, 0, 1, 0, 16'hBEEF);      key(8'h37);
      push("to_start", 1, 1, 1, 0, 0, 16'hBEEF);
      push("to_wait", 1, 0, 1, 0, 0, 16'hBEEF);
      push("to_expire", 0, 0, 0, 0, 0, 16'hBEEF);  key(8'h0D);
      check("to_flag_clear", int'(timeout), 0);
      n = 0;
      while (busy && n < 200) begin
        @(posedge clk_50m); #1;
        n++;
      end
      check("to_cycles", n, int'(TOC));
      check("to_flag", int'(timeout), 1);
    end
`endif

    repeat (4) @(posedge clk_50m);
    #1;
    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_line_ctrl.md
CALC_LINE_CTRL -- requirements
Module: calc_line_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64; line-buffer depth in characters, power of two, minimum 4.
REQ-002 SHALL have parameter AW, default 6; buffer address width, equal to log2(DEPTH).
REQ-003 SHALL have parameter RES_W, default 16; calculator result width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1000000; watchdog limit in clocks.
REQ-005 SHALL have port clk_50m, input, 1 bit; the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-007 SHALL have port ascii_in, input, 8 bits; key character.
REQ-008 SHALL have port data_ready, input, 1 bit; one key accepted per high cycle.
REQ-009 SHALL have port rd_addr, input, AW bits; calculator read address.
REQ-010 SHALL have port rd_data, output, 8 bits; buffer[rd_addr], combinational read.
REQ-011 SHALL have port calc_start, output, 1 bit; one-cycle start pulse.
REQ-012 SHALL have port calc_done, input, 1 bit; calculator completion strobe.
REQ-013 SHALL have port calc_result, input, RES_W bits; valid when calc_done is high.
REQ-014 SHALL have port result, output, RES_W bits; latched result.
REQ-015 SHALL have port done_flag, output, 1 bit; sticky completion indicator.
REQ-016 SHALL have port busy, output, 1 bit; high in states START and WAIT.
REQ-017 SHALL have port overflow, output, 1 bit; sticky indicator that a character was dropped.
REQ-018 SHALL have port len, output, AW+1 bits; current line length.

Function
REQ-019 SHALL implement three states, EDIT, START and WAIT, with EDIT as the reset state.
REQ-020 In EDIT, data_ready with printable ascii_in (0x20 to 0x7E) and len < DEPTH-1: SHALL write buffer[len] and increment len on the next edge.
REQ-021 In EDIT, a printable character with len = DEPTH-1: SHALL leave the buffer and len unchanged and set overflow.
REQ-022 In EDIT, 0x08: SHALL decrement len if len > 0; with len = 0 it SHALL have no effect.
REQ-023 In EDIT, 0x0D with len > 0: SHALL write 0x0D to buffer[len], clear done_flag and overflow, and go to START; with len = 0 it SHALL be ignored.
REQ-024 Any other ascii_in value in EDIT SHALL be ignored.
REQ-025 START SHALL last exactly one cycle, assert calc_start and go to WAIT.
REQ-026 In WAIT, calc_done SHALL latch calc_result into result, set done_flag, clear len to 0 and go to EDIT on the same edge.
REQ-027 calc_done SHALL be honoured only in WAIT.
REQ-028 In START and WAIT, data_ready SHALL be ignored, including when it coincides with calc_done.
REQ-029 rd_data SHALL reflect buffer[rd_addr] in every state with zero latency.
REQ-030 done_flag SHALL remain set until the next accepted 0x0D (no latch-like behaviour).

Reset
REQ-031 rst SHALL force state EDIT and clear len, calc_start, result, done_flag, overflow, busy and the watchdog immediately, without waiting for a clock edge.
REQ-032 Buffer contents SHALL NOT be reset.
REQ-033 rst asserted in WAIT SHALL abort the calculation; a later calc_done in EDIT SHALL be ignored.

Configuration
REQ-034 With macro CALC_TIMEOUT_EN defined: a counter SHALL run in WAIT; after TIMEOUT_CYC cycles without calc_done the block SHALL return to EDIT and clear len, with result and done_flag unchanged.
REQ-035 With CALC_TIMEOUT_EN defined: an extra output timeout (1 bit, sticky) SHALL be set on timeout and cleared on the next START.
REQ-036 Without CALC_TIMEOUT_EN: WAIT SHALL persist until calc_done or rst, and no timeout port SHALL exist.

Verification
REQ-037 Keys "1","+","2",0x0D -> buffer[0..3] = 31 2B 32 0D; calc_start pulses once, one cycle after 0x0D; busy = 1.
REQ-038 In WAIT, calc_done with calc_result = 0x0003 -> result = 0x0003, done_flag = 1, len = 0, state EDIT on the next cycle.
REQ-039 DEPTH=4: send "1234" -> len = 3 and overflow = 1; then send 0x08 -> len = 2.
REQ-040 0x0D with len = 0 -> no calc_start; keys during WAIT -> len unchanged; data_ready together with calc_done -> key dropped.
REQ-041 rst pulsed mid-WAIT, then calc_done -> result = 0, done_flag = 0, busy = 0.
REQ-042 CALC_TIMEOUT_EN defined, TIMEOUT_CYC = 20, no calc_done -> EDIT entered 20 cycles after START, timeout = 1.
